// File: rtl/linear_interp_upsampler_pkg.sv
// Shared DAC-path definitions: interpolator state encoding and width helpers
// for the linear-interpolating upsampler.
package linear_interp_upsampler_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      HOLD
   } interp_state_t;

   // Accumulator holds x*R plus headroom for one full-scale delta step.
   function automatic int acc_width(input int width, input int ratio_log2);
      return width + ratio_log2 + 1;
   endfunction

   // Difference of two full-scale samples needs one extra bit.
   function automatic int delta_width(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/linear_interp_upsampler.sv
// Linear-interpolating upsampler: emits 2^RATIO_LOG2 evenly spaced samples
// between consecutive input samples, feeding the delta-sigma modulator.
module linear_interp_upsampler
   import linear_interp_upsampler_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int RATIO_LOG2 = 6
) (
   input  logic             aclk,
   input  logic             arst,
   input  logic [WIDTH-1:0] s_axis_data_tdata,
   input  logic             s_axis_data_tvalid,
   output logic             s_axis_data_tready,
   output logic [WIDTH-1:0] m_axis_data_tdata,
   output logic             m_axis_data_tvalid,
   input  logic             m_axis_data_tready,
   output logic             underrun
);

   localparam int ACC_W   = acc_width(WIDTH, RATIO_LOG2);
   localparam int DELTA_W = delta_width(WIDTH);
   localparam logic [RATIO_LOG2-1:0] K_LAST = '1;

   interp_state_t state_q, state_d;

   // The previous sample x0 is never read back: it lives implicitly in acc,
   // whose phase-0 value is x0*R, so only x1 is kept as a register.
   logic signed [WIDTH-1:0]   x1_q;
   logic signed [DELTA_W-1:0] delta_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic [RATIO_LOG2-1:0]     k_q;
   logic                      underrun_q;

   logic                      in_hs;
   logic                      seg_load;
   logic                      last_phase;
   logic signed [ACC_W-1:0]   x1_scaled;
   logic signed [DELTA_W-1:0] delta_new;

   assign last_phase = (k_q == K_LAST);
   assign in_hs      = s_axis_data_tvalid && s_axis_data_tready;
   // Every accepted sample outside IDLE closes one segment and opens the next.
   assign seg_load   = in_hs && (state_q != IDLE);

   assign x1_scaled = ACC_W'(x1_q) <<< RATIO_LOG2;
   assign delta_new = DELTA_W'($signed(s_axis_data_tdata)) - DELTA_W'(x1_q);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d            = state_q;
      s_axis_data_tready = 1'b0;
      case (state_q)
         IDLE: begin
            s_axis_data_tready = 1'b1;
            if (s_axis_data_tvalid) state_d = FILL;
         end
         FILL: begin
            s_axis_data_tready = 1'b1;
            if (s_axis_data_tvalid) state_d = RUN;
         end
         RUN: begin
            s_axis_data_tready = m_axis_data_tready && last_phase;
            if (m_axis_data_tready && last_phase && !s_axis_data_tvalid) state_d = HOLD;
         end
         HOLD: begin
            s_axis_data_tready = 1'b1;
            if (s_axis_data_tvalid) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset
   // clears every register because a discarded segment must leave no residue.
   always_ff @(posedge aclk) begin
      if (arst) begin
         state_q    <= IDLE;
         x1_q       <= '0;
         delta_q    <= '0;
         acc_q      <= '0;
         k_q        <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         underrun_q <= (state_q == RUN) && (state_d == HOLD);
         if (in_hs) x1_q <= $signed(s_axis_data_tdata);
         if (seg_load) begin
            delta_q <= delta_new;
            acc_q   <= x1_scaled;
            k_q     <= '0;
         end else if (state_q == RUN && m_axis_data_tready) begin
            if (last_phase) begin
               acc_q <= x1_scaled;
            end else begin
               acc_q <= acc_q + ACC_W'(delta_q);
               k_q   <= k_q + 1'b1;
            end
         end
      end
   end

   assign m_axis_data_tdata  = acc_q[RATIO_LOG2 +: WIDTH];
   assign m_axis_data_tvalid = (state_q == RUN) || (state_q == HOLD);
   assign underrun           = underrun_q;

endmodule
